// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types and constants for the MIPS data-memory path.
//
//   state_t : arbiter sequencer states (IDLE -> ISSUE -> WAIT).
//   owner_t : which requester owns an access (CPU port C or debug port D).
//   OP_LW / OP_SW : primary opcodes of the two instructions that reach the
//                   data memory through port C.
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_C,
        OWN_D
    } owner_t;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/mips_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// mips_rr_arbiter2
//   Two-way combinational pick between port C (bit 0) and port D (bit 1).
//   A lone requester always wins. On contention the port that did not own
//   the previous access wins when rr_en is set; otherwise C wins.
//
//   Ports
//     req        in   [1:0]  {d_req, c_req}
//     last_owner in   owner  owner of the most recent grant
//     rr_en      in   1      1 = round-robin, 0 = fixed priority to C
//     grant      out  [1:0]  one-hot winner, 2'b00 when nothing requests
// ---------------------------------------------------------------------------
module mips_rr_arbiter2
    import mips_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       rr_en,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: grant gets a default before the case so every path assigns
        // it; a missing assignment here would infer a latch.
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (rr_en && (last_owner == OWN_C)) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_dmem_arbiter
//   Shares one synchronous-read, single-port data memory between the CPU
//   load/store stage (port C) and the debug/loader port (port D). Each
//   access is sequenced as ISSUE (memory strobe) then WAIT (read data back);
//   the next arbitration happens in WAIT, so back-to-back accesses run at
//   one every two cycles.
//
//   Timing: req sampled at edge N -> gnt + mem_en during cycle N+1
//           -> rvalid/err (and rdata for loads) during cycle N+2.
//
//   Ports
//     clk, rst                   clock, asynchronous active-high reset
//     c_req/c_we/c_addr/c_wdata  CPU command, held until c_gnt
//     c_gnt                      1-cycle pulse, command issued
//     c_rvalid/c_rdata           load data, 1-cycle pulse
//     c_err                      1-cycle pulse, address >= DEPTH
//     d_*                        same set for the debug port
//     mem_en/mem_we/mem_addr/mem_wdata  memory command (valid in ISSUE)
//     mem_rdata                  memory read data, valid the cycle after a read
//     busy                       sequencer not idle
// ---------------------------------------------------------------------------
module mips_dmem_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // Out-of-range addresses are flagged, never folded back into the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    state_t state_q, state_d;
    owner_t owner_q;
    owner_t last_owner_q;

    logic              cmd_we_q;
    logic              cmd_ok_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    logic [1:0]        req;
    logic [1:0]        grant;
    owner_t            win_owner;
    logic              win_we;
    logic              win_ok;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              arb_go;

    logic c_gnt_d, d_gnt_d;
    logic c_rvalid_d, d_rvalid_d;
    logic c_err_d, d_err_d;
    logic mem_en_d, mem_we_d;

    assign req = {d_req, c_req};

    mips_rr_arbiter2 u_arb (
        .req        (req),
        .last_owner (last_owner_q),
        .rr_en      (RR_EN != 0),
        .grant      (grant)
    );

    // Winner's command, selected from the one-hot grant.
    always_comb begin
        win_owner = grant[1] ? OWN_D   : OWN_C;
        win_we    = grant[1] ? d_we    : c_we;
        win_addr  = grant[1] ? d_addr  : c_addr;
        win_wdata = grant[1] ? d_wdata : c_wdata;
        win_ok    = in_range(win_addr);
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        arb_go     = 1'b0;
        c_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_err_d    = 1'b0;
        d_err_d    = 1'b0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_go  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The access is on the memory bus now; its response shows
                // up in WAIT, so the response flags are loaded here.
                state_d    = WAIT;
                c_rvalid_d = (owner_q == OWN_C) && !cmd_we_q;
                d_rvalid_d = (owner_q == OWN_D) && !cmd_we_q;
                c_err_d    = (owner_q == OWN_C) && !cmd_ok_q;
                d_err_d    = (owner_q == OWN_D) && !cmd_ok_q;
            end
            WAIT: begin
                if (|req) begin
                    arb_go  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_go) begin
            c_gnt_d  = grant[0];
            d_gnt_d  = grant[1];
            mem_en_d = win_ok;
            mem_we_d = win_we && win_ok;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture at the arbitration edge; the requester may change its
    // inputs afterwards without disturbing the access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the command data registers are reset as well because
            // they drive mem_addr/mem_wdata directly, which must read 0 in reset.
            owner_q      <= OWN_C;
            last_owner_q <= OWN_D;
            cmd_we_q     <= 1'b0;
            cmd_ok_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
        end else if (arb_go) begin
            owner_q      <= win_owner;
            last_owner_q <= win_owner;
            cmd_we_q     <= win_we;
            cmd_ok_q     <= win_ok;
            cmd_addr_q   <= win_addr;
            cmd_wdata_q  <= win_wdata;
        end
    end

    // Registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_err    <= 1'b0;
            d_err    <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            c_gnt    <= c_gnt_d;
            d_gnt    <= d_gnt_d;
            c_rvalid <= c_rvalid_d;
            d_rvalid <= d_rvalid_d;
            c_err    <= c_err_d;
            d_err    <= d_err_d;
            mem_en   <= mem_en_d;
            mem_we   <= mem_we_d;
            busy     <= (state_d != IDLE);
        end
    end

    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

    // The memory returns data one cycle after the strobe, so read data is
    // steered from mem_rdata in WAIT rather than registered again. Error
    // responses return zero.
    assign c_rdata = (c_rvalid && !c_err) ? mem_rdata : '0;
    assign d_rdata = (d_rvalid && !d_err) ? mem_rdata : '0;

endmodule
